// File: rtl/posit_defines.sv
// Shared constants and beat structures for the posit multiplier datapath.
package posit_defines;

    localparam int NBITS  = 32;
    localparam int ES     = 2;
    localparam int FHBITS = NBITS - ES - 2;
    localparam int MBITS  = 2 * FHBITS;
    localparam int SBITS  = 9;

    // Working vector holds the regime fill, terminator, exp, fraction and headroom for the shift
    localparam int WBITS = 2 * NBITS + MBITS;
    localparam int RBITS = $clog2(NBITS) + 1;
    localparam int KBITS = SBITS - ES;

    localparam int MAX_SCALE = (NBITS - 2) << ES;
    localparam logic signed [SBITS-1:0] SAT_HI = SBITS'(MAX_SCALE);
    localparam logic signed [SBITS-1:0] SAT_LO = SBITS'(-MAX_SCALE);

    localparam logic [NBITS-1:0] MAXPOS = {1'b0, {(NBITS-1){1'b1}}};
    localparam logic [NBITS-1:0] MINPOS = NBITS'(1);
    localparam logic [NBITS-1:0] NAR    = {1'b1, {(NBITS-1){1'b0}}};

    typedef struct packed {
        logic             sign;
        logic [SBITS-1:0] scale;
        logic [MBITS-1:0] fraction;
        logic             zero;
        logic             inf;
    } value_product;

    typedef struct packed {
        logic [NBITS-2:0] magnitude;
        logic             guard;
        logic             sticky;
        logic             sign;
        logic             zero;
        logic             inf;
        logic             saturate;
    } round_stage_t;

endpackage

// File: rtl/posit_round_pack_regime_shift.sv
// Stage-1 regime/exponent/fraction assembly and the logarithmic right shifter it uses.
module DSR_right_N_S #(
    parameter int N = 16,
    parameter int S = 4
) (
    input  logic [N-1:0] a,
    input  logic [S-1:0] b,
    output logic [N-1:0] c
);

    logic [N-1:0] stage_vec [0:S];

    assign stage_vec[0] = a;

    generate
        for (genvar gi = 0; gi < S; gi++) begin : g_stage
            assign stage_vec[gi+1] = b[gi] ? (stage_vec[gi] >> (1 << gi)) : stage_vec[gi];
        end
    endgenerate

    assign c = stage_vec[S];

endmodule

module posit_regime_shift
    import posit_defines::*;
(
    input  value_product beat,
    output round_stage_t stage
);

    localparam logic [KBITS-1:0] ONE_K    = KBITS'(1);
    localparam logic [KBITS-1:0] RUN_CLIP = KBITS'(NBITS);
    localparam int               PAD      = WBITS - NBITS - 1 - ES - MBITS;

    logic signed [SBITS-1:0] scale_s;
    logic [KBITS-1:0]        k;
    logic                    k_neg;
    logic [KBITS-1:0]        run_len;
    logic [RBITS-1:0]        shift_amt;
    logic [WBITS-1:0]        work;
    logic [WBITS-1:0]        shifted;
    logic                    sat_hi;
    logic                    sat_lo;

    assign scale_s = beat.scale;
    assign k       = beat.scale[SBITS-1:ES];
    assign k_neg   = k[KBITS-1];
    assign run_len = k_neg ? (~k + ONE_K) : (k + ONE_K);
    assign shift_amt = (run_len > RUN_CLIP) ? RBITS'(NBITS) : run_len[RBITS-1:0];

    // The top NBITS fill bits are discarded after the shift, so the window starts with run_len regime bits
    assign work = {{NBITS{~k_neg}}, k_neg, beat.scale[ES-1:0], beat.fraction, {PAD{1'b0}}};

    DSR_right_N_S #(
        .N(WBITS),
        .S(RBITS)
    ) u_shift (
        .a(work),
        .b(shift_amt),
        .c(shifted)
    );

    assign sat_hi = scale_s > SAT_HI;
    assign sat_lo = scale_s < SAT_LO;

    always_comb begin
        stage.magnitude = shifted[WBITS-NBITS-1 -: NBITS-1];
        stage.guard     = shifted[WBITS-2*NBITS];
        stage.sticky    = |shifted[WBITS-2*NBITS-1:0];
        stage.sign      = beat.sign;
        stage.zero      = beat.zero;
        stage.inf       = beat.inf;
        stage.saturate  = sat_hi | sat_lo;
        if (sat_hi) begin
            stage.magnitude = '1;
        end else if (sat_lo) begin
            stage.magnitude = (NBITS-1)'(1);
        end
    end

endmodule

// File: rtl/posit_round_pack.sv
// Two-stage round-to-nearest-even posit packer with valid/ready flow control.
// Define POSIT_ROUND_STATS_EN to build the round-up and saturation counters.
module posit_round_pack
    import posit_defines::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sign,
    input  logic [SBITS-1:0] in_scale,
    input  logic [MBITS-1:0] in_fraction,
    input  logic             in_zero,
    input  logic             in_inf,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [NBITS-1:0] out_posit,
    output logic             out_zero,
    output logic             out_inf,
    output logic [31:0]      round_up_count,
    output logic [31:0]      saturate_count
);

    value_product     in_beat;
    round_stage_t     s1_next;
    round_stage_t     s1_reg;
    logic             s1_valid_reg;
    logic             out_valid_reg;
    logic [NBITS-1:0] out_posit_reg;
    logic             out_zero_reg;
    logic             out_inf_reg;
    logic             advance1;
    logic             advance2;
    logic             rb;
    logic [NBITS-1:0] mag_sum;
    logic [NBITS-1:0] mag_final;
    logic [NBITS-1:0] posit_next;
    logic             zero_next;
    logic             inf_next;

    always_comb begin
        in_beat.sign     = in_sign;
        in_beat.scale    = in_scale;
        in_beat.fraction = in_fraction;
        in_beat.zero     = in_zero;
        in_beat.inf      = in_inf;
    end

    posit_regime_shift u_regime_shift (
        .beat (in_beat),
        .stage(s1_next)
    );

    assign advance2 = ~out_valid_reg | out_ready;
    assign advance1 = ~s1_valid_reg | advance2;
    assign in_ready = advance1;

    always_comb begin
        rb        = s1_reg.guard & (s1_reg.magnitude[0] | s1_reg.sticky);
        mag_sum   = {1'b0, s1_reg.magnitude} + {{(NBITS-1){1'b0}}, rb};
        mag_final = mag_sum;
        if (s1_reg.saturate) begin
            mag_final = {1'b0, s1_reg.magnitude};
        end else if (mag_sum[NBITS-1]) begin
            mag_final = MAXPOS;
        end else if (mag_sum == '0) begin
            mag_final = MINPOS;
        end
        posit_next = s1_reg.sign ? -mag_final : mag_final;
        zero_next  = 1'b0;
        inf_next   = 1'b0;
        // NaR wins over zero; both skip rounding entirely
        if (s1_reg.inf) begin
            posit_next = NAR;
            inf_next   = 1'b1;
        end else if (s1_reg.zero) begin
            posit_next = '0;
            zero_next  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (advance1 && in_valid) begin
            s1_reg <= s1_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            out_posit_reg <= '0;
            out_zero_reg  <= 1'b0;
            out_inf_reg   <= 1'b0;
        end else begin
            if (advance1) begin
                s1_valid_reg <= in_valid;
            end
            if (advance2) begin
                out_valid_reg <= s1_valid_reg;
                if (s1_valid_reg) begin
                    out_posit_reg <= posit_next;
                    out_zero_reg  <= zero_next;
                    out_inf_reg   <= inf_next;
                end
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_posit = out_posit_reg;
    assign out_zero  = out_zero_reg;
    assign out_inf   = out_inf_reg;

`ifdef POSIT_ROUND_STATS_EN
    logic        round_up_next;
    logic        clamp_next;
    logic        round_up_reg;
    logic        clamp_reg;
    logic [31:0] round_up_count_reg;
    logic [31:0] saturate_count_reg;

    assign round_up_next = rb & ~s1_reg.saturate & ~s1_reg.inf & ~s1_reg.zero;
    assign clamp_next    = ~s1_reg.inf & ~s1_reg.zero &
                           (s1_reg.saturate | mag_sum[NBITS-1] | (mag_sum == '0));

    // Flags ride with the output word so counting happens only on actual transfer
    always_ff @(posedge clk) begin
        if (reset) begin
            round_up_reg       <= 1'b0;
            clamp_reg          <= 1'b0;
            round_up_count_reg <= '0;
            saturate_count_reg <= '0;
        end else begin
            if (advance2 && s1_valid_reg) begin
                round_up_reg <= round_up_next;
                clamp_reg    <= clamp_next;
            end
            if (out_valid_reg && out_ready) begin
                if (round_up_reg) begin
                    round_up_count_reg <= round_up_count_reg + 32'd1;
                end
                if (clamp_reg) begin
                    saturate_count_reg <= saturate_count_reg + 32'd1;
                end
            end
        end
    end

    assign round_up_count = round_up_count_reg;
    assign saturate_count = saturate_count_reg;
`else
    assign round_up_count = '0;
    assign saturate_count = '0;
`endif

endmodule

// File: doc/posit_round_pack.md
Name: posit_round_pack

Overview:
- Downstream stage of the posit multiplier.
- Takes the unrounded product (sign, scale, MSB-aligned fraction with the hidden bit already removed, zero/inf flags) and produces a correctly rounded posit word.
- Rounding mode: round-to-nearest-even, with saturation to minpos/maxpos.
- 2-stage valid/ready pipeline with full-throughput backpressure; sits between the multiplier and the PairHMM result consumer.

Parameters:
NBITS, 32, posit width
ES, 2, exponent bits
SBITS, 9, width of signed scale input
MBITS, 56, width of product fraction input (2*FHBITS, FHBITS = NBITS-ES-2 = 28)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  input beat valid
in_ready  out  1  stage can accept input
in_sign  in  1  product sign
in_scale  in  SBITS  signed product scale (2^scale)
in_fraction  in  MBITS  fraction bits, MSB = first bit after hidden bit
in_zero  in  1  product is zero
in_inf  in  1  product is NaR
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_posit  out  NBITS  rounded posit
out_zero  out  1  result is zero
out_inf  out  1  result is NaR
round_up_count  out  32  count of results incremented by rounding (optional feature)
saturate_count  out  32  count of results clamped to minpos/maxpos (optional feature)

Behaviour:
- One clock (clk); reset is synchronous and active-high.
- Reset values:
  - s1_valid = 0, out_valid = 0.
  - out_posit = 0, out_zero = 0, out_inf = 0.
  - Both counters = 0.
- Latency: 2 cycles from accepted input to out_valid; throughput 1 beat/cycle.
- Handshake:
  - Input is accepted when in_valid & in_ready.
  - Output is transferred when out_valid & out_ready.
  - advance2 = !out_valid | out_ready; advance1 = !s1_valid | advance2; in_ready = advance1.
  - Registers hold their values when not advancing.
  - Simultaneous accept and output transfer is legal.
  - No beat is dropped or duplicated; results leave in input order.
- Stage 1 (regime build):
  - k = in_scale >>> ES (arithmetic shift).
  - exp = in_scale[ES-1:0].
  - Run length = k+1 if k >= 0, otherwise -k.
  - Form {regime bits, terminator, exp, fraction} MSB-aligned in a 2*NBITS+MBITS working vector.
  - Shift right by the run length (clipped to NBITS).
  - Register the top NBITS-1 bits as the unrounded magnitude.
  - Register guard bit, sticky (OR of all lower bits), sign, zero, inf.
  - Saturation flag = scale > (NBITS-2)<<ES (120) or scale < -(NBITS-2)<<ES (-120).
- Stage 2 (round/pack):
  - lsb = magnitude[0].
  - rb = (lsb & guard) | (guard & sticky); magnitude += rb.
  - Overflow of the magnitude into the sign position clamps to maxpos 0x7FFFFFFF.
  - A nonzero product never rounds to 0; the minimum magnitude is 1.
  - Saturation forces magnitude 0x7FFFFFFF (positive scale) or 0x00000001 (negative scale), and rb is ignored.
  - Negative sign: the result is the two's complement of {0, magnitude}.
- Special cases:
  - inf has priority over zero.
  - inf: out_posit = 0x80000000, out_inf = 1.
  - zero: out_posit = 0, out_zero = 1.
  - Both bypass rounding.
- Reset mid-operation: all in-flight beats are discarded; in_ready = 1 in the cycle after reset deasserts.

Optional Feature:
- Macro POSIT_ROUND_STATS_EN.
- Defined:
  - round_up_count increments on each transferred output where rb=1 and no special/saturation case applies.
  - saturate_count increments on each transferred output that was clamped.
  - Both counters wrap at 2^32 and clear on reset.
- Undefined: both ports tied to 0 and no counter registers are generated.

Decomposition:
- posit_defines package:
  - NBITS, ES, FHBITS, MBITS, SBITS constants.
  - value_product struct (sign, scale, fraction, zero, inf), used to carry the input beat.
  - New struct round_stage_t: magnitude, guard, sticky, sign, zero, inf, saturate.
- One sub-module: posit_regime_shift, the combinational stage-1 regime/exp/fraction assembly and right shift, reusing DSR_right_N_S.

Test Plan:
- scale=0, fraction=0, sign=0 -> 0x40000000; same with sign=1 -> 0xC0000000; result 2 cycles after accept.
- scale=0, fraction=1<<28 (tie, lsb 0) -> 0x40000000; fraction=(1<<28)|1 -> 0x40000001; fraction=(1<<29)|(1<<28) -> 0x40000002.
- scale=125 -> 0x7FFFFFFF; scale=-125 -> 0x00000001; sign=1, scale=125 -> 0x80000001; saturate_count=3 with macro defined.
- in_zero=1 -> 0x00000000 with out_zero=1; in_zero=1 and in_inf=1 -> 0x80000000 with out_inf=1.
- Feed 4 beats back-to-back with out_ready=0 for 5 cycles: in_ready drops after 2 beats are held; after release all 4 results emerge in order with none lost.
- Assert reset with 2 beats in flight: out_valid=0 next cycle, no stale output, counters=0.
